// File: rtl/pcie_rx_merge_logic.sv
`default_nettype none
// ============================================================================
// Module      : pcie_rx_merge_logic
// Description : Drains the D0/D1 destination FIFOs with round-robin pops and
//               merges their words into one ordered stream through an internal
//               output FIFO with a configurable almost-full margin.
// Revision    : 1.0 - initial release
// ============================================================================
module pcie_rx_merge_logic #(
    parameter int DATA_WIDTH = 6,
    parameter int DEPTH      = 8,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  init,
    input  logic [3:0]            umbral_out,
    input  logic [DATA_WIDTH-1:0] data_in_D0,
    input  logic                  empty_fifo_D0,
    output logic                  D0_pop,
    input  logic [DATA_WIDTH-1:0] data_in_D1,
    input  logic                  empty_fifo_D1,
    output logic                  D1_pop,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid_out,
    input  logic                  rd_ready,
    output logic                  error_out,
    output logic                  active_out,
    output logic                  idle_out
);

    // Wide enough to hold count + pending + umbral without overflow
    localparam int c_sum_w = ADDR_WIDTH + 4;
    localparam int c_cnt_w = ADDR_WIDTH + 1;
    localparam logic [c_sum_w-1:0] c_depth_s = c_sum_w'(DEPTH);
    localparam logic [c_cnt_w-1:0] c_depth_c = c_cnt_w'(DEPTH);

    typedef enum logic [2:0] {
        ST_RESET  = 3'd0,
        ST_INIT   = 3'd1,
        ST_IDLE   = 3'd2,
        ST_ACTIVE = 3'd3,
        ST_ERROR  = 3'd4
    } state_t;

    state_t                  r_state;
    logic [3:0]              r_umbral;
    logic [DATA_WIDTH-1:0]   r_mem [DEPTH];
    logic [ADDR_WIDTH-1:0]   r_wr_ptr;
    logic [ADDR_WIDTH-1:0]   r_rd_ptr;
    logic [c_cnt_w-1:0]      r_count;
    logic                    r_pend;      // a pop was issued last cycle
    logic                    r_pend_src;  // 1: that pop went to D1
    logic                    r_last;      // last served FIFO, 1 = D1

    logic [c_sum_w-1:0]      w_fill;
    logic                    w_pop_ok;
    logic                    w_want0;
    logic                    w_want1;
    logic                    w_full;
    logic                    w_wr;
    logic                    w_ovf;
    logic                    w_rd;
    logic [DATA_WIDTH-1:0]   w_cap_data;

    // Headroom includes the word already in flight so the margin is never overrun
    assign w_fill   = c_sum_w'(r_count) + c_sum_w'(r_pend) + c_sum_w'(r_umbral);
    assign w_pop_ok = ((r_state == ST_IDLE) || (r_state == ST_ACTIVE)) && (w_fill < c_depth_s);

    // Round-robin: on a tie the FIFO not served last wins
    assign w_want0 = !empty_fifo_D0 && (empty_fifo_D1 || r_last);
    assign w_want1 = !empty_fifo_D1 && (empty_fifo_D0 || !r_last);
    assign D0_pop  = w_pop_ok && w_want0;
    assign D1_pop  = w_pop_ok && w_want1;

    assign w_full     = (r_count == c_depth_c);
    assign w_wr       = r_pend && !w_full;
    assign w_ovf      = r_pend && w_full;
    assign w_cap_data = r_pend_src ? data_in_D1 : data_in_D0;

    assign valid_out = (r_count != '0);
    assign data_out  = r_mem[r_rd_ptr];
    assign w_rd      = valid_out && rd_ready;

    assign error_out  = (r_state == ST_ERROR);
    assign active_out = (r_state == ST_ACTIVE);
    assign idle_out   = (r_state == ST_IDLE);

    // Capture popped words, track in-flight pop and drain to the consumer
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_pend     <= 1'b0;
            r_pend_src <= 1'b0;
            r_last     <= 1'b1;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            r_pend     <= D0_pop || D1_pop;
            r_pend_src <= D1_pop;
            if (D0_pop) begin
                r_last <= 1'b0;
            end else if (D1_pop) begin
                r_last <= 1'b1;
            end
            if (w_wr) begin
                r_mem[r_wr_ptr] <= w_cap_data;
                r_wr_ptr        <= r_wr_ptr + ADDR_WIDTH'(1);
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + ADDR_WIDTH'(1);
            end
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + c_cnt_w'(1);
                2'b01:   r_count <= r_count - c_cnt_w'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Control state machine; a dropped word forces the sticky error state
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_RESET;
            r_umbral <= '0;
        end else begin
            case (r_state)
                ST_RESET: r_state <= ST_INIT;
                ST_INIT: begin
                    r_umbral <= umbral_out;
                    if (!init) begin
                        if ((r_umbral == 4'd0) || (c_sum_w'(r_umbral) >= c_depth_s)) begin
                            r_state <= ST_ERROR;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end
                end
                ST_IDLE: begin
                    if (init) begin
                        r_state <= ST_INIT;
                    end else if (!empty_fifo_D0 || !empty_fifo_D1) begin
                        r_state <= ST_ACTIVE;
                    end
                end
                ST_ACTIVE: begin
                    if (init) begin
                        r_state <= ST_INIT;
                    end else if (empty_fifo_D0 && empty_fifo_D1 && !r_pend && (r_count == '0)) begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_ERROR: r_state <= ST_ERROR;
                default:  r_state <= ST_RESET;
            endcase
            if (w_ovf) begin
                r_state <= ST_ERROR;
            end
        end
    end

endmodule
`default_nettype wire
